// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone parallel-prefix adder/subtractor with valid/ready on both sides.
// Optional zero/ovf flag outputs are enabled by defining PREFIX_ADDER_FLAGS_EN.
module pipelined_prefix_adder #(
  parameter int WIDTH     = 16,
  parameter int PIPE_TREE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PREFIX_ADDER_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int LEVELS = $clog2(WIDTH);

  // Handshake: a beat enters on in_valid && in_ready and leaves on out_valid && out_ready.
  // The whole pipe advances together unless a held result is not being taken.
  logic adv;
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  logic [WIDTH-1:0] b_eff, p_new, g_new;
  logic             c0_new;

  always_comb begin
    b_eff  = sub ? ~b : b;
    c0_new = sub | cin;
    p_new  = a ^ b_eff;
    g_new  = a & b_eff;
    // Carry-in folded into bit 0 so the tree needs no separate carry path
    g_new[0] = g_new[0] | (p_new[0] & c0_new);
  end

  logic [WIDTH-1:0] s0_p, s0_g;
  logic             s0_c0, s0_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_v  <= 1'b0;
      s0_p  <= '0;
      s0_g  <= '0;
      s0_c0 <= 1'b0;
    end else if (adv) begin
      s0_v <= in_valid;
      if (in_valid) begin
        s0_p  <= p_new;
        s0_g  <= g_new;
        s0_c0 <= c0_new;
      end
    end
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int D = 1 << l;
    logic [WIDTH-1:0] p_in, g_in, pr_in, p_nxt, g_nxt, p_out, g_out, pr_out;
    logic             c0_in, v_in, c0_out, v_out;

    if (l == 0) begin : g_src
      // Raw propagate doubles as the level-0 group propagate
      assign p_in  = s0_p;
      assign g_in  = s0_g;
      assign pr_in = s0_p;
      assign c0_in = s0_c0;
      assign v_in  = s0_v;
    end else begin : g_src
      assign p_in  = g_lvl[l-1].p_out;
      assign g_in  = g_lvl[l-1].g_out;
      assign pr_in = g_lvl[l-1].pr_out;
      assign c0_in = g_lvl[l-1].c0_out;
      assign v_in  = g_lvl[l-1].v_out;
    end

    always_comb begin
      p_nxt = p_in;
      g_nxt = g_in;
      for (int i = D; i < WIDTH; i++) begin
        p_nxt[i] = p_in[i] & p_in[i-D];
        g_nxt[i] = g_in[i] | (p_in[i] & g_in[i-D]);
      end
    end

    if (PIPE_TREE != 0) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_out  <= 1'b0;
          p_out  <= '0;
          g_out  <= '0;
          pr_out <= '0;
          c0_out <= 1'b0;
        end else if (adv) begin
          v_out  <= v_in;
          p_out  <= p_nxt;
          g_out  <= g_nxt;
          pr_out <= pr_in;
          c0_out <= c0_in;
        end
      end
    end else begin : g_comb
      assign v_out  = v_in;
      assign p_out  = p_nxt;
      assign g_out  = g_nxt;
      assign pr_out = pr_in;
      assign c0_out = c0_in;
    end
  end

  logic [WIDTH-1:0] t_g, t_pr, carry_vec, sum_nxt;
  logic             t_c0, t_v;
  logic             unused_t_p;

  assign t_g        = g_lvl[LEVELS-1].g_out;
  assign t_pr       = g_lvl[LEVELS-1].pr_out;
  assign t_c0       = g_lvl[LEVELS-1].c0_out;
  assign t_v        = g_lvl[LEVELS-1].v_out;
  assign unused_t_p = ^g_lvl[LEVELS-1].p_out;

  // carry into bit i is the group generate of bits i-1..0
  assign carry_vec = {t_g[WIDTH-2:0], t_c0};
  assign sum_nxt   = t_pr ^ carry_vec;

  // Result registers only change on a real beat so they stay 0 until the first result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef PREFIX_ADDER_FLAGS_EN
      zero      <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else if (adv) begin
      out_valid <= t_v;
      if (t_v) begin
        sum  <= sum_nxt;
        cout <= t_g[WIDTH-1];
`ifdef PREFIX_ADDER_FLAGS_EN
        zero <= (sum_nxt == '0);
        ovf  <= t_g[WIDTH-1] ^ carry_vec[WIDTH-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Self-checking bench for pipelined_prefix_adder: WIDTH=16/PIPE_TREE=1 plus two WIDTH=4 builds.
// Flag outputs are checked when PREFIX_ADDER_FLAGS_EN is defined.
module tb_pipelined_prefix_adder;

`ifdef PREFIX_ADDER_FLAGS_EN
  localparam logic [18:0] FMASK = 19'h7ffff;
`else
  localparam logic [18:0] FMASK = 19'h1ffff;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 16-bit DUT
  logic        iv, ir, ov, ordy, cin, sub, cout, zero, ovf;
  logic [15:0] a, b, sum;

  // two 4-bit DUTs share their inputs
  logic       iv4, cin4, sub4, ordy4;
  logic [3:0] a4, b4;
  logic       ir4a, ov4a, cout4a, zero4a, ovf4a;
  logic       ir4b, ov4b, cout4b, zero4b, ovf4b;
  logic [3:0] sum4a, sum4b;

  int n_checks = 0;
  int n_fail   = 0;
  logic [18:0] exp_q[$];
  logic [18:0] exp4a_q[$];
  logic [18:0] exp4b_q[$];

  pipelined_prefix_adder #(.WIDTH(16), .PIPE_TREE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov), .out_ready(ordy), .sum(sum), .cout(cout)
`ifdef PREFIX_ADDER_FLAGS_EN
    , .zero(zero), .ovf(ovf)
`endif
  );

  pipelined_prefix_adder #(.WIDTH(4), .PIPE_TREE(0)) dut4a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4a), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .out_valid(ov4a), .out_ready(ordy4), .sum(sum4a), .cout(cout4a)
`ifdef PREFIX_ADDER_FLAGS_EN
    , .zero(zero4a), .ovf(ovf4a)
`endif
  );

  pipelined_prefix_adder #(.WIDTH(4), .PIPE_TREE(1)) dut4b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4b), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .out_valid(ov4b), .out_ready(ordy4), .sum(sum4b), .cout(cout4b)
`ifdef PREFIX_ADDER_FLAGS_EN
    , .zero(zero4b), .ovf(ovf4b)
`endif
  );

`ifndef PREFIX_ADDER_FLAGS_EN
  assign zero   = 1'b0;
  assign ovf    = 1'b0;
  assign zero4a = 1'b0;
  assign ovf4a  = 1'b0;
  assign zero4b = 1'b0;
  assign ovf4b  = 1'b0;
`endif

  // Reference: plain integer arithmetic. Result layout {ovf, zero, cout, sum[15:0]}.
  function automatic logic [18:0] model(input int w, input int ua, input int ub,
                                        input logic ci, input logic sb);
    int m, half, tot, sa, sbv, sr;
    logic [18:0] r;
    r    = '0;
    m    = 1 << w;
    half = m / 2;
    sa   = (ua >= half) ? ua - m : ua;
    sbv  = (ub >= half) ? ub - m : ub;
    if (sb) begin
      tot   = ua - ub;
      sr    = sa - sbv;
      r[16] = (ua >= ub);
    end else begin
      tot   = ua + ub + int'(ci);
      sr    = sa + sbv + int'(ci);
      r[16] = (tot >= m);
    end
    tot      = ((tot % m) + m) % m;
    r[15:0]  = tot[15:0];
    r[17]    = (tot == 0);
    r[18]    = (sr < -half) || (sr >= half);
    return r & FMASK;
  endfunction

  task automatic drive16(input logic v, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tc, input logic ts, input logic rdy,
                         output logic acc, output logic cons, output logic [18:0] obs,
                         output logic irdy, output logic ovo);
    iv = v; a = ta; b = tb; cin = tc; sub = ts; ordy = rdy;
    #1;
    acc  = v && ir;
    cons = ov && rdy;
    irdy = ir;
    ovo  = ov;
    obs  = {ovf, zero, cout, sum} & FMASK;
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic v, input logic [3:0] ta, input logic [3:0] tb,
                        input logic tc, input logic ts,
                        output logic acc_a, output logic acc_b, output logic cons_a, output logic cons_b,
                        output logic [18:0] oa, output logic [18:0] ob);
    iv4 = v; a4 = ta; b4 = tb; cin4 = tc; sub4 = ts; ordy4 = 1'b1;
    #1;
    acc_a  = v && ir4a;
    acc_b  = v && ir4b;
    cons_a = ov4a;
    cons_b = ov4b;
    oa = {ovf4a, zero4a, cout4a, 12'h000, sum4a} & FMASK;
    ob = {ovf4b, zero4b, cout4b, 12'h000, sum4b} & FMASK;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; ordy = 1'b0;
    iv4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0; ordy4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", ov); end
    n_checks++; if (sum !== 16'h0) begin n_fail++; $display("FAIL reset_sum: got %h expected 0000", sum); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b expected 0", cout); end
    n_checks++; if ({zero, ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {zero, ovf}); end
    n_checks++; if ({ov4a, ov4b} !== 2'b00) begin n_fail++; $display("FAIL reset_out_valid4: got %b expected 00", {ov4a, ov4b}); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (ir !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", ir); end
  endtask

  task automatic test_directed();
    logic [15:0] va [4] = '{16'h1234, 16'hFFFF, 16'h0005, 16'h8000};
    logic [15:0] vb [4] = '{16'h4321, 16'h0000, 16'h0007, 16'h0001};
    logic        vc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic        vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [18:0] ve [4] = '{19'h05555, 19'h30000, 19'h0FFFE, 19'h57FFF};
    logic acc, cons, irdy, ovo;
    logic [18:0] obs, got;
    int lat;
    for (int t = 0; t < 4; t++) begin
      drive16(1'b1, va[t], vb[t], vc[t], vs[t], 1'b1, acc, cons, obs, irdy, ovo);
      lat = 0;
      got = '0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
        drive16(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc, cons, obs, irdy, ovo);
        if (cons) begin lat = k; got = obs; end
      end
      n_checks++; if (lat != 6) begin n_fail++; $display("FAIL directed%0d_latency: got %0d expected 6", t, lat); end
      n_checks++; if (got !== (ve[t] & FMASK)) begin n_fail++; $display("FAIL directed%0d_result: got %h expected %h", t, got, ve[t] & FMASK); end
    end
  endtask

  task automatic test_backpressure();
    logic acc, cons, irdy, ovo, rdy, prev_stall;
    logic [18:0] obs, e;
    logic [15:0] held;
    int k, got, c;
    k = 1; got = 0; c = 0; prev_stall = 1'b0; held = '0;
    exp_q.delete();
    while (got < 10 && c < 100) begin
      rdy = !(c >= 8 && c <= 11);
      drive16(k <= 10, 16'(k), 16'(k), 1'b0, 1'b0, rdy, acc, cons, obs, irdy, ovo);
      if (ovo && !rdy) begin
        n_checks++; if (irdy !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready c=%0d: got %b expected 0", c, irdy); end
        if (prev_stall) begin
          n_checks++; if (obs[15:0] !== held) begin n_fail++; $display("FAIL stall_sum_hold c=%0d: got %h expected %h", c, obs[15:0], held); end
        end
        held = obs[15:0];
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (cons) begin
        got++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 19'h7ffff;
        n_checks++; if (obs !== e || obs[15:0] !== 16'(2 * got)) begin n_fail++; $display("FAIL bp_result%0d: got %h expected %h", got, obs, e); end
      end
      if (acc) begin exp_q.push_back(model(16, k, k, 1'b0, 1'b0)); k++; end
      c++;
    end
    n_checks++; if (got != 10 || k != 11 || exp_q.size() != 0) begin n_fail++; $display("FAIL bp_count: got %0d results %0d sent expected 10 10", got, k - 1); end
  endtask

  task automatic test_back_to_back();
    logic acc, cons, irdy, ovo, rc, rs;
    logic [15:0] ra, rb;
    logic [18:0] obs, e;
    int sent, got, c;
    sent = 0; got = 0; c = 0;
    exp_q.delete();
    while (got < 30 && c < 100) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      drive16(sent < 30, ra, rb, rc, rs, 1'b1, acc, cons, obs, irdy, ovo);
      if (cons) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 19'h7ffff;
        n_checks++; if (obs !== e || c != 6 + got) begin n_fail++; $display("FAIL b2b_result%0d: got %h at cycle %0d expected %h at cycle %0d", got, obs, c, e, 6 + got); end
        got++;
      end
      if (acc) begin exp_q.push_back(model(16, int'(ra), int'(rb), rc, rs)); sent++; end
      c++;
    end
    n_checks++; if (got != 30) begin n_fail++; $display("FAIL b2b_count: got %0d expected 30", got); end
  endtask

  task automatic test_random_stream();
    logic acc, cons, irdy, ovo, v, rdy, rc, rs;
    logic [15:0] ra, rb;
    logic [18:0] obs, e;
    int sent, got, c;
    sent = 0; got = 0; c = 0;
    exp_q.delete();
    while (got < 200 && c < 3000) begin
      v   = (sent < 200) && ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 9) < 7);
      ra  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      rc  = 1'($urandom); rs = 1'($urandom);
      drive16(v, ra, rb, rc, rs, rdy, acc, cons, obs, irdy, ovo);
      if (cons) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 19'h7ffff;
        n_checks++; if (obs !== e) begin n_fail++; $display("FAIL rand_result%0d: got %h expected %h", got, obs, e); end
        got++;
      end
      if (acc) begin exp_q.push_back(model(16, int'(ra), int'(rb), rc, rs)); sent++; end
      c++;
    end
    n_checks++; if (got != 200) begin n_fail++; $display("FAIL rand_count: got %0d expected 200", got); end
  endtask

  task automatic test_reset_mid();
    logic acc, cons, irdy, ovo;
    logic [18:0] obs, got;
    int stale, lat;
    // leave a nonzero result in the output register first
    drive16(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, acc, cons, obs, irdy, ovo);
    for (int k = 0; k < 10; k++) drive16(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc, cons, obs, irdy, ovo);
    for (int k = 0; k < 4; k++) drive16(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1, acc, cons, obs, irdy, ovo);
    rst_n = 1'b0;
    #1;
    n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %b expected 0", ov); end
    n_checks++; if (sum !== 16'h0 || cout !== 1'b0) begin n_fail++; $display("FAIL midreset_sum: got %h/%b expected 0000/0", sum, cout); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_checks++; if (ir !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %b expected 1", ir); end
    stale = 0;
    for (int k = 0; k < 12; k++) begin
      drive16(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc, cons, obs, irdy, ovo);
      if (cons) stale++;
    end
    n_checks++; if (stale != 0) begin n_fail++; $display("FAIL midreset_stale: got %0d results expected 0", stale); end
    drive16(1'b1, 16'h0F0F, 16'h1111, 1'b1, 1'b0, 1'b1, acc, cons, obs, irdy, ovo);
    lat = 0; got = '0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      drive16(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc, cons, obs, irdy, ovo);
      if (cons) begin lat = k; got = obs; end
    end
    n_checks++; if (lat != 6) begin n_fail++; $display("FAIL midreset_latency: got %0d expected 6", lat); end
    n_checks++; if (got !== model(16, 16'h0F0F, 16'h1111, 1'b1, 1'b0)) begin n_fail++; $display("FAIL midreset_result: got %h expected %h", got, model(16, 16'h0F0F, 16'h1111, 1'b1, 1'b0)); end
  endtask

  task automatic test_exhaustive4();
    logic acc_a, acc_b, cons_a, cons_b;
    logic [18:0] oa, ob, e;
    logic [9:0] idx;
    int sent, got_a, got_b, c, first_a, first_b;
    sent = 0; got_a = 0; got_b = 0; c = 0; first_a = -1; first_b = -1;
    exp4a_q.delete(); exp4b_q.delete();
    while ((got_a < 1024 || got_b < 1024) && c < 1200) begin
      idx = 10'(sent);
      drive4(sent < 1024, idx[3:0], idx[7:4], idx[8], idx[9], acc_a, acc_b, cons_a, cons_b, oa, ob);
      if (cons_a) begin
        if (first_a < 0) first_a = c;
        e = (exp4a_q.size() != 0) ? exp4a_q.pop_front() : 19'h7ffff;
        n_checks++; if (oa !== e) begin n_fail++; $display("FAIL exh_pipe0_%0d: got %h expected %h", got_a, oa, e); end
        got_a++;
      end
      if (cons_b) begin
        if (first_b < 0) first_b = c;
        e = (exp4b_q.size() != 0) ? exp4b_q.pop_front() : 19'h7ffff;
        n_checks++; if (ob !== e) begin n_fail++; $display("FAIL exh_pipe1_%0d: got %h expected %h", got_b, ob, e); end
        got_b++;
      end
      if (acc_a) exp4a_q.push_back(model(4, int'(idx[3:0]), int'(idx[7:4]), idx[8], idx[9]));
      if (acc_b) exp4b_q.push_back(model(4, int'(idx[3:0]), int'(idx[7:4]), idx[8], idx[9]));
      if (sent < 1024 && acc_a && acc_b) sent++;
      c++;
    end
    n_checks++; if (first_a != 2) begin n_fail++; $display("FAIL exh_pipe0_latency: got %0d expected 2", first_a); end
    n_checks++; if (first_b != 4) begin n_fail++; $display("FAIL exh_pipe1_latency: got %0d expected 4", first_b); end
    n_checks++; if (got_a != 1024 || got_b != 1024) begin n_fail++; $display("FAIL exh_count: got %0d/%0d expected 1024/1024", got_a, got_b); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random_stream();
    test_reset_mid();
    test_exhaustive4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
